sam_control_unit: RTL and testbench

SAM_CONTROL_UNIT -- requirements
Module: sam_control_unit

---
 rtl/sam_control_unit_pkg.sv | 65 ++++++
 rtl/sam_control_unit_decode.sv | 88 ++++++++
 rtl/sam_control_unit.sv | 86 ++++++++
 tb/tb_sam_control_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sam_control_unit_pkg.sv
// Shared encodings for the SAM control unit: states, opcodes, mux and ALU codes.
package sam_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_IND   = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8;
  localparam logic [3:0] OP_BZ  = 4'h9;
  localparam logic [3:0] OP_BNZ = 4'hA;
  localparam logic [3:0] OP_LDN = 4'hB;
  localparam logic [3:0] OP_STN = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Accumulator input mux
  localparam logic [1:0] ACC_SEL_NONE = 2'b00;
  localparam logic [1:0] ACC_SEL_TGT  = 2'b01;
  localparam logic [1:0] ACC_SEL_BUS  = 2'b10;
  localparam logic [1:0] ACC_SEL_ALU  = 2'b11;

  // ALU function
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Full set of control strobes produced by the decoder
  typedef struct packed {
    logic       ireg_en;
    logic       pc_en;
    logic       iar_en;
    logic       acc_en;
    logic       pc_buf;
    logic       ireg_buf;
    logic       iar_buf;
    logic       acc_buf;
    logic       pc_add_sel;
    logic       pc_in_sel;
    logic [1:0] acc_in_sel;
    logic [1:0] alu_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
  } ctrl_t;

  // Opcodes that need an indirect-address cycle before execute
  function automatic logic is_ind(input logic [3:0] op);
    return (op == OP_LDN) || (op == OP_STN);
  endfunction

endpackage

// File: rtl/sam_control_unit_decode.sv
// Combinational control decode: state + opcode + accumulator-zero -> strobes.
module sam_ctrl_decode
  import sam_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  output ctrl_t      ctrl
);

  // Every strobe defaults low; each state/opcode raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.pc_buf     = 1'b1;
        ctrl.mem_rd     = 1'b1;
        ctrl.ireg_en    = 1'b1;
        ctrl.pc_en      = 1'b1;
        ctrl.pc_add_sel = 1'b1;
        ctrl.pc_in_sel  = 1'b1;
      end
      S_IND: begin
        ctrl.ireg_buf = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.iar_en   = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_LDI: begin
            ctrl.acc_en     = 1'b1;
            ctrl.acc_in_sel = ACC_SEL_TGT;
          end
          OP_LDA: begin
            ctrl.ireg_buf   = 1'b1;
            ctrl.mem_rd     = 1'b1;
            ctrl.acc_en     = 1'b1;
            ctrl.acc_in_sel = ACC_SEL_BUS;
          end
          OP_STA: begin
            ctrl.ireg_buf = 1'b1;
            ctrl.acc_buf  = 1'b1;
            ctrl.mem_wr   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.ireg_buf   = 1'b1;
            ctrl.mem_rd     = 1'b1;
            ctrl.acc_en     = 1'b1;
            ctrl.acc_in_sel = ACC_SEL_ALU;
            ctrl.alu_sel    = opcode[1:0];
          end
          // Relative branch: PC (already incremented) + target
          OP_BR, OP_BZ, OP_BNZ: begin
            if ((opcode == OP_BR) ||
                (opcode == OP_BZ  &&  acc_zero) ||
                (opcode == OP_BNZ && !acc_zero)) begin
              ctrl.pc_en      = 1'b1;
              ctrl.pc_add_sel = 1'b0;
              ctrl.pc_in_sel  = 1'b1;
            end
          end
          OP_LDN: begin
            ctrl.iar_buf    = 1'b1;
            ctrl.mem_rd     = 1'b1;
            ctrl.acc_en     = 1'b1;
            ctrl.acc_in_sel = ACC_SEL_BUS;
          end
          OP_STN: begin
            ctrl.iar_buf = 1'b1;
            ctrl.acc_buf = 1'b1;
            ctrl.mem_wr  = 1'b1;
          end
          // Absolute jump: PC loaded from memory word at target
          OP_JMP: begin
            ctrl.ireg_buf  = 1'b1;
            ctrl.mem_rd    = 1'b1;
            ctrl.pc_en     = 1'b1;
            ctrl.pc_in_sel = 1'b0;
          end
          default: ;  // NOP, reserved E and HLT assert nothing
        endcase
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sam_control_unit.sv
// SAM control unit top: state register, next-state logic, retired-instruction counter.
module sam_control_unit
  import sam_control_unit_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       IReg_Data_Out,
  input  logic [7:0]       Acc_Data_Out,
  output logic             IReg_En,
  output logic             PC_En,
  output logic             IAR_En,
  output logic             Acc_En,
  output logic             PC_Buffer_Sel,
  output logic             IReg_Buffer_Sel,
  output logic             IAR_Buffer_Sel,
  output logic             Acc_Buffer_Sel,
  output logic             Mux_PC_Add_Sel,
  output logic             Mux_PC_In_Sel,
  output logic [1:0]       Mux_Acc_In_Sel,
  output logic [1:0]       ALU_Sel,
  output logic             Mem_Rd,
  output logic             Mem_Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t     state, nxt;
  ctrl_t      ctrl;
  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode         = IReg_Data_Out[7:4];
  // Operand target field feeds the datapath, not control
  assign unused_operand = ^IReg_Data_Out[3:0];

  // State register; reset wins over every transition
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state selection
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: nxt = is_ind(opcode) ? S_IND : S_EXEC;
      S_IND:   nxt = S_EXEC;
      S_EXEC:  nxt = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // One count per execute cycle, wrapping naturally at all-ones
  always_ff @(posedge clk) begin
    if (rst)                 Instr_Count <= '0;
    else if (state == S_EXEC) Instr_Count <= Instr_Count + 1'b1;
  end

  sam_ctrl_decode u_decode (
    .state    (state),
    .opcode   (opcode),
    .acc_zero (Acc_Data_Out == 8'h00),
    .ctrl     (ctrl)
  );

  assign IReg_En         = ctrl.ireg_en;
  assign PC_En           = ctrl.pc_en;
  assign IAR_En          = ctrl.iar_en;
  assign Acc_En          = ctrl.acc_en;
  assign PC_Buffer_Sel   = ctrl.pc_buf;
  assign IReg_Buffer_Sel = ctrl.ireg_buf;
  assign IAR_Buffer_Sel  = ctrl.iar_buf;
  assign Acc_Buffer_Sel  = ctrl.acc_buf;
  assign Mux_PC_Add_Sel  = ctrl.pc_add_sel;
  assign Mux_PC_In_Sel   = ctrl.pc_in_sel;
  assign Mux_Acc_In_Sel  = ctrl.acc_in_sel;
  assign ALU_Sel         = ctrl.alu_sel;
  assign Mem_Rd          = ctrl.mem_rd;
  assign Mem_Wr          = ctrl.mem_wr;
  assign Halted          = ctrl.halted;

endmodule

// File: tb/tb_sam_control_unit.sv
// Directed table-driven bench for sam_control_unit.
module tb_sam_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ireg = 8'h00;
  logic [7:0] acc = 8'h00;
  logic IReg_En, PC_En, IAR_En, Acc_En;
  logic PC_Buffer_Sel, IReg_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel;
  logic Mux_PC_Add_Sel, Mux_PC_In_Sel, Mem_Rd, Mem_Wr, Halted;
  logic [1:0] Mux_Acc_In_Sel, ALU_Sel;
  logic [7:0] Instr_Count;

  int checks = 0;
  int errors = 0;

  sam_control_unit #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .IReg_Data_Out(ireg), .Acc_Data_Out(acc),
    .IReg_En(IReg_En), .PC_En(PC_En), .IAR_En(IAR_En), .Acc_En(Acc_En),
    .PC_Buffer_Sel(PC_Buffer_Sel), .IReg_Buffer_Sel(IReg_Buffer_Sel),
    .IAR_Buffer_Sel(IAR_Buffer_Sel), .Acc_Buffer_Sel(Acc_Buffer_Sel),
    .Mux_PC_Add_Sel(Mux_PC_Add_Sel), .Mux_PC_In_Sel(Mux_PC_In_Sel),
    .Mux_Acc_In_Sel(Mux_Acc_In_Sel), .ALU_Sel(ALU_Sel),
    .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Halted(Halted), .Instr_Count(Instr_Count)
  );

  always #5 clk = ~clk;

  // Output word, MSB first: IReg_En .. Halted
  logic [16:0] word;
  assign word = {IReg_En, PC_En, IAR_En, Acc_En, PC_Buffer_Sel, IReg_Buffer_Sel,
                 IAR_Buffer_Sel, Acc_Buffer_Sel, Mux_PC_Add_Sel, Mux_PC_In_Sel,
                 Mux_Acc_In_Sel, ALU_Sel, Mem_Rd, Mem_Wr, Halted};

  localparam logic [16:0] IREN   = 17'h10000;
  localparam logic [16:0] PCEN   = 17'h08000;
  localparam logic [16:0] IAREN  = 17'h04000;
  localparam logic [16:0] ACCEN  = 17'h02000;
  localparam logic [16:0] PCB    = 17'h01000;
  localparam logic [16:0] IRB    = 17'h00800;
  localparam logic [16:0] IAB    = 17'h00400;
  localparam logic [16:0] ACB    = 17'h00200;
  localparam logic [16:0] ADD1   = 17'h00100;
  localparam logic [16:0] INADD  = 17'h00080;
  localparam logic [16:0] AS_TGT = 17'h00020;
  localparam logic [16:0] AS_BUS = 17'h00040;
  localparam logic [16:0] AS_ALU = 17'h00060;
  localparam logic [16:0] ALU01  = 17'h00008;
  localparam logic [16:0] ALU10  = 17'h00010;
  localparam logic [16:0] ALU11  = 17'h00018;
  localparam logic [16:0] RD     = 17'h00004;
  localparam logic [16:0] WR     = 17'h00002;
  localparam logic [16:0] HLT    = 17'h00001;

  localparam logic [16:0] W_FETCH = IREN | PCEN | PCB | ADD1 | INADD | RD;
  localparam logic [16:0] W_IND   = IRB | RD | IAREN;

  typedef struct {
    logic [7:0]  ireg;
    logic [7:0]  acc;
    logic        ind;
    logic [16:0] exec_w;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply reset for two edges and release; DUT sits in IDLE afterwards
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("idle_word", {15'd0, word}, 32'd0);
    check("idle_count", {24'd0, Instr_Count}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 17'h0};
    vecs[1]  = '{8'h15, 8'h00, 1'b0, ACCEN | AS_TGT};
    vecs[2]  = '{8'h2A, 8'h00, 1'b0, IRB | RD | ACCEN | AS_BUS};
    vecs[3]  = '{8'h35, 8'h00, 1'b0, IRB | ACB | WR};
    vecs[4]  = '{8'h47, 8'h00, 1'b0, IRB | RD | ACCEN | AS_ALU};
    vecs[5]  = '{8'h51, 8'h00, 1'b0, IRB | RD | ACCEN | AS_ALU | ALU01};
    vecs[6]  = '{8'h62, 8'h00, 1'b0, IRB | RD | ACCEN | AS_ALU | ALU10};
    vecs[7]  = '{8'h73, 8'h00, 1'b0, IRB | RD | ACCEN | AS_ALU | ALU11};
    vecs[8]  = '{8'h84, 8'h07, 1'b0, PCEN | INADD};
    vecs[9]  = '{8'h93, 8'h00, 1'b0, PCEN | INADD};
    vecs[10] = '{8'h93, 8'h01, 1'b0, 17'h0};
    vecs[11] = '{8'hA2, 8'h00, 1'b0, 17'h0};
    vecs[12] = '{8'hA2, 8'h05, 1'b0, PCEN | INADD};
    vecs[13] = '{8'hB4, 8'h00, 1'b1, IAB | RD | ACCEN | AS_BUS};
    vecs[14] = '{8'hC6, 8'h00, 1'b1, IAB | ACB | WR};
    vecs[15] = '{8'hD9, 8'h00, 1'b0, IRB | RD | PCEN};
    vecs[16] = '{8'hE0, 8'h00, 1'b0, 17'h0};

    // Per-opcode pass: IDLE -> FETCH -> [IND] -> EXEC -> FETCH
    for (int v = 0; v < 17; v++) begin
      ireg = vecs[v].ireg;
      acc  = vecs[v].acc;
      do_reset();
      tick();
      check($sformatf("fetch_%h_%h", vecs[v].ireg, vecs[v].acc), {15'd0, word}, {15'd0, W_FETCH});
      if (vecs[v].ind) begin
        tick();
        check($sformatf("ind_%h", vecs[v].ireg), {15'd0, word}, {15'd0, W_IND});
      end
      tick();
      check($sformatf("exec_%h_%h", vecs[v].ireg, vecs[v].acc), {15'd0, word}, {15'd0, vecs[v].exec_w});
      check($sformatf("exec_cnt_%h", vecs[v].ireg), {24'd0, Instr_Count}, 32'd0);
      tick();
      check($sformatf("refetch_%h", vecs[v].ireg), {15'd0, word}, {15'd0, W_FETCH});
      check($sformatf("retired_%h", vecs[v].ireg), {24'd0, Instr_Count}, 32'd1);
    end

    // HLT: halted from the cycle after EXEC, held, count frozen at 1
    ireg = 8'hF0;
    acc  = 8'h00;
    do_reset();
    tick();
    tick();
    check("hlt_exec", {15'd0, word}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("halt_%0d", i), {15'd0, word}, {15'd0, HLT});
    end
    check("halt_count", {24'd0, Instr_Count}, 32'd1);
    // Reset out of HALT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_word", {15'd0, word}, 32'd0);
    check("halt_rst_count", {24'd0, Instr_Count}, 32'd0);

    // Reset during IND with a nonzero count
    ireg = 8'hB4;
    do_reset();
    tick(); tick(); tick();   // FETCH, IND, EXEC
    tick();                   // FETCH, count 1
    check("ind_rst_pre_count", {24'd0, Instr_Count}, 32'd1);
    tick();
    check("ind_rst_in_ind", {15'd0, word}, {15'd0, W_IND});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ind_rst_word", {15'd0, word}, 32'd0);
    check("ind_rst_count", {24'd0, Instr_Count}, 32'd0);
    tick();
    check("ind_rst_fetch", {15'd0, word}, {15'd0, W_FETCH});

    // 256 NOPs wrap the counter back to zero
    ireg = 8'h00;
    do_reset();
    tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      tick();
      if (i == 0)   check("wrap_1", {24'd0, Instr_Count}, 32'd1);
      if (i == 254) check("wrap_255", {24'd0, Instr_Count}, 32'd255);
      if (i == 255) check("wrap_0", {24'd0, Instr_Count}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
